// File: rtl/axis_fifo_sync.sv
// Synchronous AXI-Stream FIFO with full sideband (tdata/tkeep/tlast/tid/tdest/tuser).
// Ports: aclk, areset (sync, active-high); s_axis_* input beat with s_axis_tready;
//   m_axis_* output beat with m_axis_tready; count = occupancy 0..DEPTH.
// Optional: define AXIS_FIFO_FRAME_EN to hold output until a whole packet is stored.
module axis_fifo_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [ID_WIDTH-1:0]        s_axis_tid,
  input  logic [DEST_WIDTH-1:0]      s_axis_tdest,
  input  logic [USER_WIDTH-1:0]      s_axis_tuser,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [ID_WIDTH-1:0]        m_axis_tid,
  output logic [DEST_WIDTH-1:0]      m_axis_tdest,
  output logic [USER_WIDTH-1:0]      m_axis_tuser,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1
                    + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_next;
  logic [PW-1:0] rd_next;
  logic          ready_q;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          full_next;

  logic [EW-1:0]         wdata;
  logic [EW-1:0]         rdata;
  logic [DATA_WIDTH-1:0] r_data;
  logic [KEEP_WIDTH-1:0] r_keep;
  logic                  r_last;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [USER_WIDTH-1:0] r_user;

  // Disabled fields are stored as zero so they cost nothing after synthesis.
  assign wdata = {
    s_axis_tdata,
    (KEEP_ENABLE != 0) ? s_axis_tkeep : {KEEP_WIDTH{1'b0}},
    s_axis_tlast,
    (ID_ENABLE   != 0) ? s_axis_tid   : {ID_WIDTH{1'b0}},
    (DEST_ENABLE != 0) ? s_axis_tdest : {DEST_WIDTH{1'b0}},
    (USER_ENABLE != 0) ? s_axis_tuser : {USER_WIDTH{1'b0}}
  };

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign push = s_axis_tvalid && ready_q;
  assign pop  = m_axis_tvalid && m_axis_tready;

  assign wr_next = wr_ptr + PW'(push);
  assign rd_next = rd_ptr + PW'(pop);

  assign full_next = (wr_next[AW] != rd_next[AW]) &&
                     (wr_next[AW-1:0] == rd_next[AW-1:0]);

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_next;
      rd_ptr  <= rd_next;
      ready_q <= !full_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (push && !areset)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Read from registered pointers only: a new beat appears the edge after
  // it is written, never combinationally from the input.
  assign rdata = mem[rd_ptr[AW-1:0]];
  assign {r_data, r_keep, r_last, r_id, r_dest, r_user} = rdata;

`ifdef AXIS_FIFO_FRAME_EN
  logic [PW-1:0] frames;
  logic          draining;
  logic          last_in;
  logic          last_out;

  assign last_in  = push && s_axis_tlast;
  assign last_out = pop && r_last;

  always_ff @(posedge aclk) begin
    if (areset) begin
      frames   <= '0;
      draining <= 1'b0;
    end else begin
      if (last_in && !last_out)
        frames <= frames + 1'b1;
      else if (!last_in && last_out && frames != '0)
        frames <= frames - 1'b1;
      // A frame released early (full escape) keeps flowing up to its tlast.
      if (pop)
        draining <= !r_last;
    end
  end

  assign m_axis_tvalid = !empty &&
                         ((frames != '0) || full || draining);
`else
  assign m_axis_tvalid = !empty;
`endif

  assign s_axis_tready = ready_q;

  assign m_axis_tdata = m_axis_tvalid ? r_data : '0;
  assign m_axis_tlast = m_axis_tvalid && r_last;
  assign m_axis_tkeep = (KEEP_ENABLE == 0) ? {KEEP_WIDTH{1'b1}} :
                        (m_axis_tvalid ? r_keep : {KEEP_WIDTH{1'b0}});
  assign m_axis_tid   = m_axis_tvalid ? r_id   : '0;
  assign m_axis_tdest = m_axis_tvalid ? r_dest : '0;
  assign m_axis_tuser = m_axis_tvalid ? r_user : '0;

  assign count = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_axis_fifo_sync.sv
// Self-checking bench for axis_fifo_sync: directed table plus
// hand-written full/stream/throttle sequences (and frame-mode cases).
module tb_axis_fifo_sync;

  localparam int DW = 16;
  localparam int KW = 2;
  localparam int IW = 4;
  localparam int SW = 3;
  localparam int UW = 4;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [IW-1:0] s_tid;
  logic [SW-1:0] s_tdest;
  logic [UW-1:0] s_tuser;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [IW-1:0] m_tid;
  logic [SW-1:0] m_tdest;
  logic [UW-1:0] m_tuser;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axis_fifo_sync #(
    .DATA_WIDTH(DW), .KEEP_ENABLE(1), .KEEP_WIDTH(KW),
    .ID_ENABLE(1), .ID_WIDTH(IW), .DEST_ENABLE(1), .DEST_WIDTH(SW),
    .USER_ENABLE(1), .USER_WIDTH(UW), .DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .count(count)
  );

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          ev;
    logic          er;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[6];
  logic [29:0] q[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    tick();
    areset = 1'b0;
    tick();
  endtask

  initial begin
    areset = 1'b1;
    s_tdata = '0; s_tkeep = 2'b11; s_tvalid = 1'b0; s_tlast = 1'b1;
    s_tid = '0; s_tdest = '0; s_tuser = '0; m_tready = 1'b0;

    // Reset held three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_tready", s_tready, 0);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_count", count, 0);
      chk("rst_tdata", m_tdata, 0);
    end
    areset = 1'b0;
    tick();
    chk("rel_tready", s_tready, 1);
    chk("rel_tvalid", m_tvalid, 0);
    chk("rel_count", count, 0);

    // Directed table: push, push, pop, push+pop, pop, idle.
    tbl[0] = '{1'b1, 16'h00A1, 1'b0, 1'b1, 1'b1, 5'd1, 16'h00A1};
    tbl[1] = '{1'b1, 16'h00A2, 1'b0, 1'b1, 1'b1, 5'd2, 16'h00A1};
    tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 5'd1, 16'h00A2};
    tbl[3] = '{1'b1, 16'h00A3, 1'b1, 1'b1, 1'b1, 5'd1, 16'h00A3};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 5'd0, 16'h0000};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 5'd0, 16'h0000};
    s_tlast = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_tvalid = tbl[i].sv;
      s_tdata  = tbl[i].sd;
      m_tready = tbl[i].mr;
      tick();
      chk($sformatf("tbl%0d_tvalid", i), m_tvalid, tbl[i].ev);
      chk($sformatf("tbl%0d_tready", i), s_tready, tbl[i].er);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].ec);
      chk($sformatf("tbl%0d_tdata", i), m_tdata, tbl[i].ed);
    end

    // Fill to full, check backpressure, then drain in order.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_tvalid = 1'b1;
      s_tdata = DW'(i);
      tick();
    end
    chk("full_count", count, 16);
    chk("full_tready", s_tready, 0);
    chk("full_tvalid", m_tvalid, 1);
    s_tdata = 16'h00FF;
    tick();
    chk("full_hold_count", count, 16);
    chk("full_hold_data", m_tdata, 0);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_tvalid", i), m_tvalid, 1);
      chk($sformatf("drain%0d_data", i), m_tdata, i);
      tick();
      if (i == 0) chk("drain_tready_back", s_tready, 1);
    end
    chk("drain_count", count, 0);
    chk("drain_tvalid", m_tvalid, 0);

    // Continuous streaming: one beat in flight, no bubbles.
    do_reset();
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = 16'd0;
    tick();
    for (int k = 1; k < 100; k++) begin
      chk($sformatf("str%0d_tvalid", k), m_tvalid, 1);
      chk($sformatf("str%0d_count", k), count, 1);
      chk($sformatf("str%0d_data", k), m_tdata, k - 1);
      s_tdata = DW'(k);
      tick();
    end
    chk("str_last_data", m_tdata, 99);
    s_tvalid = 1'b0;
    tick();
    chk("str_end_count", count, 0);

    // Random throttle on both sides with a scoreboard.
    begin
      int sent;
      int got;
      int cyc;
      logic acc;
      logic [29:0] act;
      logic [29:0] exp;
      sent = 0; got = 0; cyc = 0;
      do_reset();
      while (got < 1000 && cyc < 20000) begin
        if (!s_tvalid && sent < 1000 && $urandom_range(1) == 1) begin
          s_tdata  = DW'($urandom);
          s_tkeep  = KW'($urandom);
          s_tlast  = (sent == 999) ? 1'b1 : 1'(($urandom % 4) == 0);
          s_tid    = IW'($urandom);
          s_tdest  = SW'($urandom);
          s_tuser  = UW'($urandom);
          s_tvalid = 1'b1;
        end
        m_tready = 1'($urandom_range(1));
        @(negedge aclk);
        acc = s_tvalid && s_tready;
        if (m_tvalid && m_tready) begin
          act = {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
          if (q.size() > 0) exp = q.pop_front();
          else exp = ~act;
          chk($sformatf("rnd%0d_beat", got), act, exp);
          got++;
        end
        if (acc) begin
          q.push_back({s_tdata, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser});
          sent++;
        end
        tick();
        if (acc) s_tvalid = 1'b0;
        cyc++;
      end
      chk("rnd_received", got, 1000);
      m_tready = 1'b0;
      s_tkeep = 2'b11; s_tid = '0; s_tdest = '0; s_tuser = '0;
    end

`ifdef AXIS_FIFO_FRAME_EN
    // Output held until the frame's tlast is stored.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata = DW'(16'h50 + i);
      s_tlast = (i == 2);
      tick();
      chk($sformatf("frm%0d_tvalid", i), m_tvalid, (i == 2));
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("frm_out%0d", i), m_tdata, 16'h50 + i);
      chk($sformatf("frm_last%0d", i), m_tlast, (i == 2));
      tick();
    end
    chk("frm_count", count, 0);

    // Full FIFO without tlast escapes, then reset mid-drain.
    do_reset();
    s_tlast = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_tvalid = 1'b1;
      s_tdata = DW'(i);
      tick();
    end
    s_tvalid = 1'b0;
    chk("esc_tvalid", m_tvalid, 1);
    m_tready = 1'b1;
    tick();
    chk("esc_count", count, 15);
    chk("esc_drain_tvalid", m_tvalid, 1);
    areset = 1'b1;
    m_tready = 1'b0;
    tick();
    chk("esc_rst_count", count, 0);
    chk("esc_rst_tvalid", m_tvalid, 0);
    areset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
